// File: rtl/f_fetch_pkg.sv
// Shared constants and helpers for the fetch stage: reset/exception vectors,
// the instruction-memory window and the exception codes raised in fetch.
package f_fetch_pkg;

  localparam int DATA_W = 32;
  localparam int EXC_W  = 5;

  localparam logic [DATA_W-1:0] PC_RESET  = 32'h0000_3000;
  localparam logic [DATA_W-1:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [DATA_W-1:0] IM_LO     = 32'h0000_3000;
  localparam logic [DATA_W-1:0] IM_HI     = 32'h0000_6FFC;
  localparam logic [DATA_W-1:0] INSTR_NOP = 32'h0000_0000;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

  // A fetch address is bad if it is misaligned or outside the instruction memory.
  function automatic logic addr_err(input logic [DATA_W-1:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  endfunction

endpackage

// File: rtl/f_fetch_fd_reg.sv
// F/D pipeline register: reset, flush-to-redirect-target, stall-hold or capture.
module fd_reg
  import f_fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] flush_pc,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [EXC_W-1:0]  exc_in,
  input  logic              bd_in,
  output logic [DATA_W-1:0] pc_d,
  output logic [DATA_W-1:0] instr_d,
  output logic [EXC_W-1:0]  exc_d,
  output logic              bd_d
);

  // F -> D stage boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_d    <= PC_RESET;
      instr_d <= INSTR_NOP;
      exc_d   <= EXC_NONE;
      bd_d    <= 1'b0;
    end else if (flush) begin
      pc_d    <= flush_pc;
      instr_d <= INSTR_NOP;
      exc_d   <= EXC_NONE;
      bd_d    <= 1'b0;
    end else if (!stall) begin
      pc_d    <= pc_in;
      instr_d <= instr_in;
      exc_d   <= exc_in;
      bd_d    <= bd_in;
    end
  end

endmodule

// File: rtl/f_fetch.sv
// Fetch stage: PC register with exception/eret redirect, fetch address check,
// and the F/D pipeline register.
module f_fetch
  import f_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC,
  input  logic        Stall,
  input  logic        ReqExc,
  input  logic        EretReq,
  input  logic [31:0] EPC,
  input  logic        IsBranchD,
  input  logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC_D,
  output logic [31:0] Instr_D,
  output logic [4:0]  ExcCode_D,
  output logic        BD_D
);

  logic [DATA_W-1:0] pc_p0;
  logic              adel_p0;
  logic              eret_go;
  logic              flush;
  logic [DATA_W-1:0] flush_pc;
  logic [DATA_W-1:0] instr_cap;
  logic [EXC_W-1:0]  exc_cap;

  // An eret waiting behind a stall is taken on the first unstalled edge.
  assign eret_go  = EretReq && !Stall;
  assign flush    = ReqExc || eret_go;
  assign flush_pc = ReqExc ? EXC_ENTRY : EPC;

  assign adel_p0   = addr_err(pc_p0);
  assign instr_cap = adel_p0 ? INSTR_NOP : Instr_F;
  assign exc_cap   = adel_p0 ? EXC_ADEL : EXC_NONE;

  // PC register (F stage)
  always_ff @(posedge clk) begin
    if (reset)
      pc_p0 <= PC_RESET;
    else if (ReqExc)
      pc_p0 <= EXC_ENTRY;
    else if (eret_go)
      pc_p0 <= EPC;
    else if (!Stall)
      pc_p0 <= NPC;
  end

  assign PC_F = pc_p0;

  fd_reg #(.DATA_W(DATA_W)) u_fd_reg (
    .clk      (clk),
    .reset    (reset),
    .stall    (Stall),
    .flush    (flush),
    .flush_pc (flush_pc),
    .pc_in    (pc_p0),
    .instr_in (instr_cap),
    .exc_in   (exc_cap),
    .bd_in    (IsBranchD),
    .pc_d     (PC_D),
    .instr_d  (Instr_D),
    .exc_d    (ExcCode_D),
    .bd_d     (BD_D)
  );

endmodule

// File: tb/tb_f_fetch.sv
// Bench for f_fetch: directed vector table for the listed scenarios, then
// randomized traffic against a rule-level reference model.
module tb_f_fetch;

  logic        clk = 1'b0;
  logic        reset, Stall, ReqExc, EretReq, IsBranchD;
  logic [31:0] NPC, EPC, Instr_F;
  logic [31:0] PC_F, PC_D, Instr_D;
  logic [4:0]  ExcCode_D;
  logic        BD_D;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_pc, m_pcd, m_instr;
  logic [4:0]  m_exc;
  logic        m_bd;

  always #5 clk = ~clk;

  f_fetch dut (
    .clk(clk), .reset(reset), .NPC(NPC), .Stall(Stall), .ReqExc(ReqExc),
    .EretReq(EretReq), .EPC(EPC), .IsBranchD(IsBranchD), .Instr_F(Instr_F),
    .PC_F(PC_F), .PC_D(PC_D), .Instr_D(Instr_D), .ExcCode_D(ExcCode_D), .BD_D(BD_D)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  always_comb Instr_F = imem(PC_F);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model by the stage rules, compare after the edge.
  task automatic cyc(input logic r, st, rx, er, br, input logic [31:0] npc, epc);
    logic bad;
    reset = r; Stall = st; ReqExc = rx; EretReq = er; IsBranchD = br; NPC = npc; EPC = epc;
    @(posedge clk);
    bad = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h6FFC);
    if (r) begin
      m_pc = 32'h3000; m_pcd = 32'h3000; m_instr = 0; m_exc = 0; m_bd = 0;
    end else if (rx) begin
      m_pc = 32'h4180; m_pcd = 32'h4180; m_instr = 0; m_exc = 0; m_bd = 0;
    end else if (er && !st) begin
      m_pc = epc; m_pcd = epc; m_instr = 0; m_exc = 0; m_bd = 0;
    end else if (!st) begin
      m_pcd = m_pc; m_instr = bad ? 32'h0 : imem(m_pc); m_exc = bad ? 5'd4 : 5'd0; m_bd = br;
      m_pc = npc;
    end
    #1;
    check("model_pc_f", PC_F, m_pc);
    check("model_pc_d", PC_D, m_pcd);
    check("model_instr_d", Instr_D, m_instr);
    check("model_exc_d", {27'd0, ExcCode_D}, {27'd0, m_exc});
    check("model_bd_d", {31'd0, BD_D}, {31'd0, m_bd});
  endtask

  typedef struct {
    logic        r, st, rx, er, br;
    logic [31:0] npc, epc;
    logic [31:0] e_pcf, e_pcd;
    logic        e_nop;   // 1: Instr_D must be nop, 0: Instr_D must be imem(e_pcd)
    logic [4:0]  e_exc;
    logic        e_bd;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, st, rx, er, br, input logic [31:0] npc, epc,
                     input logic [31:0] pcf, pcd, input logic nop, input logic [4:0] exc,
                     input logic bd);
    vec_t v;
    v.r = r; v.st = st; v.rx = rx; v.er = er; v.br = br; v.npc = npc; v.epc = epc;
    v.e_pcf = pcf; v.e_pcd = pcd; v.e_nop = nop; v.e_exc = exc; v.e_bd = bd;
    vt.push_back(v);
  endtask

  initial begin
    m_pc = 32'h3000; m_pcd = 32'h3000; m_instr = 0; m_exc = 0; m_bd = 0;
    reset = 1; Stall = 0; ReqExc = 0; EretReq = 0; IsBranchD = 0; NPC = 0; EPC = 0;

    //   r  st rx er br  npc       epc       PC_F      PC_D     nop exc bd
    add(1, 0, 0, 0, 0, 32'h0000, 32'h0000, 32'h3000, 32'h3000, 1, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0000, 32'h0000, 32'h3000, 32'h3000, 1, 0, 0);
    add(0, 0, 0, 0, 0, 32'h3004, 32'h0000, 32'h3004, 32'h3000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h3008, 32'h0000, 32'h3008, 32'h3004, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h300C, 32'h0000, 32'h300C, 32'h3008, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h3010, 32'h0000, 32'h3010, 32'h300C, 0, 0, 0);
    add(0, 1, 0, 0, 0, 32'h3014, 32'h0000, 32'h3010, 32'h300C, 0, 0, 0);
    add(0, 1, 0, 0, 0, 32'h3014, 32'h0000, 32'h3010, 32'h300C, 0, 0, 0);
    add(0, 1, 0, 0, 0, 32'h3014, 32'h0000, 32'h3010, 32'h300C, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h3014, 32'h0000, 32'h3014, 32'h3010, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h3020, 32'h0000, 32'h3020, 32'h3014, 0, 0, 0);
    add(0, 1, 1, 0, 0, 32'h3024, 32'h0000, 32'h4180, 32'h4180, 1, 0, 0);
    add(0, 1, 0, 1, 0, 32'h4184, 32'h3040, 32'h4180, 32'h4180, 1, 0, 0);
    add(0, 0, 0, 1, 0, 32'h4184, 32'h3040, 32'h3040, 32'h3040, 1, 0, 0);
    add(0, 0, 0, 0, 0, 32'h3002, 32'h0000, 32'h3002, 32'h3040, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h3004, 32'h0000, 32'h3004, 32'h3002, 1, 4, 0);
    add(0, 0, 0, 0, 0, 32'h7000, 32'h0000, 32'h7000, 32'h3004, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h3008, 32'h0000, 32'h3008, 32'h7000, 1, 4, 0);
    add(0, 0, 0, 0, 1, 32'h300C, 32'h0000, 32'h300C, 32'h3008, 0, 0, 1);
    add(0, 0, 0, 0, 0, 32'h3010, 32'h0000, 32'h3010, 32'h300C, 0, 0, 0);
    add(0, 0, 1, 1, 0, 32'h3014, 32'h3040, 32'h4180, 32'h4180, 1, 0, 0);
    add(1, 1, 1, 0, 0, 32'h4184, 32'h0000, 32'h3000, 32'h3000, 1, 0, 0);
    add(0, 1, 0, 0, 0, 32'h3004, 32'h0000, 32'h3000, 32'h3000, 1, 0, 0);
    add(0, 0, 0, 0, 0, 32'h3004, 32'h0000, 32'h3004, 32'h3000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h6FFC, 32'h0000, 32'h6FFC, 32'h3004, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h2FFC, 32'h0000, 32'h2FFC, 32'h6FFC, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h3000, 32'h0000, 32'h3000, 32'h2FFC, 1, 4, 0);

    @(negedge clk);
    foreach (vt[i]) begin
      cyc(vt[i].r, vt[i].st, vt[i].rx, vt[i].er, vt[i].br, vt[i].npc, vt[i].epc);
      check($sformatf("vec%0d_pc_f", i), PC_F, vt[i].e_pcf);
      check($sformatf("vec%0d_pc_d", i), PC_D, vt[i].e_pcd);
      check($sformatf("vec%0d_instr_d", i), Instr_D,
            vt[i].e_nop ? 32'h0 : imem(vt[i].e_pcd));
      check($sformatf("vec%0d_exc_d", i), {27'd0, ExcCode_D}, {27'd0, vt[i].e_exc});
      check($sformatf("vec%0d_bd_d", i), {31'd0, BD_D}, {31'd0, vt[i].e_bd});
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] npc, epc;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6)      npc = m_pc + 32'd4;
      else if (sel < 8) npc = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
      else              npc = $urandom;
      epc = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, npc, epc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
